// File: rtl/risc8_pkg.sv
// Shared constants for the risc8 execute/memory slice: widths, opcodes, ALU codes.
package risc8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_LDI  = 4'b0100;
  localparam logic [3:0] OP_ST   = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_ADDI = 4'b1011;
  localparam logic [3:0] OP_LD   = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

endpackage

// File: rtl/risc8_alu.sv
// Combinational 8-bit ALU; all results wrap modulo 2**DATA_W, carries are dropped.
module risc8_alu
  import risc8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: result = {a[DATA_W-2:0], 1'b0};
      ALU_SHR: result = {1'b0, a[DATA_W-1:1]};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/risc8_exec_mem.sv
// Execute/memory slice: opcode decode, ALU, 256x8 data memory and write-back select.
module risc8_exec_mem
  import risc8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] imm,
  output logic              rf_we,
  output logic              mem_we,
  output logic              alu_src,
  output logic [2:0]        alu_op,
  output logic              halt,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] alu_b;

  // Unknown and reserved opcodes fall to the default arm, leaving every strobe low.
  always_comb begin
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    halt    = 1'b0;
    case (opcode)
      OP_ADD:  begin rf_we = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin rf_we = 1'b1; alu_op = ALU_SUB; end
      OP_AND:  begin rf_we = 1'b1; alu_op = ALU_AND; end
      OP_LDI:  begin rf_we = 1'b1; alu_src = 1'b1; end
      OP_ST:   begin mem_we = 1'b1; alu_src = 1'b1; end
      OP_OR:   begin rf_we = 1'b1; alu_op = ALU_OR; end
      OP_XOR:  begin rf_we = 1'b1; alu_op = ALU_XOR; end
      OP_NOT:  begin rf_we = 1'b1; alu_op = ALU_NOT; end
      OP_SHL:  begin rf_we = 1'b1; alu_op = ALU_SHL; end
      OP_SHR:  begin rf_we = 1'b1; alu_op = ALU_SHR; end
      OP_ADDI: begin rf_we = 1'b1; alu_src = 1'b1; end
      OP_LD:   begin rf_we = 1'b1; alu_src = 1'b1; end
      OP_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = alu_src ? imm : rt_data;

  risc8_alu u_alu (
    .a      (rs_data),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_out),
    .zero   (zero)
  );

  // Reset clears the whole array and takes priority over a pending store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[imm] <= rt_data;
    end
  end

  assign mem_rdata = mem[imm];

  always_comb begin
    wb_data = alu_out;
    if (opcode == OP_LDI)     wb_data = imm;
    else if (opcode == OP_LD) wb_data = mem_rdata;
  end

endmodule

// File: tb/tb_risc8_exec_mem.sv
// Directed bench for risc8_exec_mem with hand-computed expected values.
module tb_risc8_exec_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] rs_data, rt_data, imm;
  logic       rf_we, mem_we, alu_src, halt, zero;
  logic [2:0] alu_op;
  logic [7:0] alu_out, mem_rdata, wb_data;

  int n_pass = 0;
  int n_total = 0;

  risc8_exec_mem dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm       (imm),
    .rf_we     (rf_we),
    .mem_we    (mem_we),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .halt      (halt),
    .alu_out   (alu_out),
    .zero      (zero),
    .mem_rdata (mem_rdata),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [3:0] op, input logic [7:0] rs, input logic [7:0] rt,
                       input logic [7:0] im);
    @(negedge clk);
    opcode = op; rs_data = rs; rt_data = rt; imm = im;
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic we_rf, input logic we_mem,
                            input logic src, input logic [2:0] op, input logic hlt);
    check({tag, "_rf_we"},   {7'd0, rf_we},   {7'd0, we_rf});
    check({tag, "_mem_we"},  {7'd0, mem_we},  {7'd0, we_mem});
    check({tag, "_alu_src"}, {7'd0, alu_src}, {7'd0, src});
    check({tag, "_alu_op"},  {5'd0, alu_op},  {5'd0, op});
    check({tag, "_halt"},    {7'd0, halt},    {7'd0, hlt});
  endtask

  initial begin
    rst = 1'b1; opcode = 4'h0; rs_data = 8'h00; rt_data = 8'h00; imm = 8'h20;
    repeat (2) @(posedge clk);
    drive(4'h0, 8'h00, 8'h00, 8'h20);
    rst = 1'b0;
    #1;
    check("reset_mem20", mem_rdata, 8'h00);
    check_ctrl("nop", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // ALU sweep
    drive(4'h1, 8'd200, 8'd100, 8'h00);
    check("add_out", alu_out, 8'd44);
    check("add_wb", wb_data, 8'd44);
    check_ctrl("add", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(4'h2, 8'd5, 8'd7, 8'h00);
    check("sub_out", alu_out, 8'd254);
    check("sub_zero", {7'd0, zero}, 8'd0);
    drive(4'h3, 8'hF0, 8'h3C, 8'h00);
    check("and_out", alu_out, 8'h30);
    drive(4'h6, 8'hF0, 8'h3C, 8'h00);
    check("or_out", alu_out, 8'hFC);
    check_ctrl("or", 1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
    drive(4'h7, 8'hF0, 8'h3C, 8'h00);
    check("xor_out", alu_out, 8'hCC);
    drive(4'h8, 8'h0F, 8'h00, 8'h00);
    check("not_out", alu_out, 8'hF0);
    drive(4'h9, 8'h81, 8'h00, 8'h00);
    check("shl_out", alu_out, 8'h02);
    check_ctrl("shl", 1'b1, 1'b0, 1'b0, 3'b110, 1'b0);
    drive(4'hA, 8'h81, 8'h00, 8'h00);
    check("shr_out", alu_out, 8'h40);
    check_ctrl("shr", 1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
    drive(4'h2, 8'd9, 8'd9, 8'h00);
    check("sub_eq_out", alu_out, 8'd0);
    check("sub_eq_zero", {7'd0, zero}, 8'd1);

    // Immediate forms
    drive(4'h4, 8'd3, 8'd0, 8'd42);
    check("ldi_wb", wb_data, 8'd42);
    check_ctrl("ldi", 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    drive(4'hB, 8'd10, 8'd99, 8'd5);
    check("addi_out", alu_out, 8'd15);
    check("addi_wb", wb_data, 8'd15);
    check_ctrl("addi", 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);

    // Store then load
    drive(4'h5, 8'h00, 8'h5A, 8'h10);
    check_ctrl("st", 1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    check("st_old_rdata", mem_rdata, 8'h00);
    drive(4'hC, 8'h00, 8'h00, 8'h10);
    check("ld10_rdata", mem_rdata, 8'h5A);
    check("ld10_wb", wb_data, 8'h5A);
    check_ctrl("ld", 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    drive(4'h5, 8'h00, 8'h11, 8'h00);
    drive(4'h5, 8'h00, 8'h22, 8'hFF);
    drive(4'hC, 8'h00, 8'h00, 8'h00);
    check("ld00_wb", wb_data, 8'h11);
    drive(4'hC, 8'h00, 8'h00, 8'hFF);
    check("ldff_wb", wb_data, 8'h22);

    // Reset mid-program clears memory
    drive(4'h5, 8'h00, 8'h77, 8'h20);
    drive(4'hC, 8'h00, 8'h00, 8'h20);
    check("ld20_before_rst", wb_data, 8'h77);
    drive(4'h0, 8'h00, 8'h00, 8'h20);
    rst = 1'b1;
    drive(4'hC, 8'h00, 8'h00, 8'h20);
    rst = 1'b0;
    #1;
    check("ld20_after_rst", mem_rdata, 8'h00);
    drive(4'hC, 8'h00, 8'h00, 8'h10);
    check("ld10_after_rst", mem_rdata, 8'h00);

    // Store held under reset is suppressed; strobes still follow the opcode
    drive(4'h5, 8'h00, 8'h99, 8'h30);
    rst = 1'b1;
    #1;
    check("st_in_rst_mem_we", {7'd0, mem_we}, 8'd1);
    drive(4'hC, 8'h00, 8'h00, 8'h30);
    rst = 1'b0;
    #1;
    check("ld30_after_rst_st", mem_rdata, 8'h00);

    // HALT and reserved opcodes
    drive(4'hF, 8'h12, 8'h34, 8'h56);
    check_ctrl("halt", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    drive(4'hD, 8'h00, 8'h55, 8'h40);
    check_ctrl("op1101", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(4'hE, 8'h00, 8'h66, 8'h40);
    check_ctrl("op1110", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(4'hC, 8'h00, 8'h00, 8'h40);
    check("ld40_untouched", mem_rdata, 8'h00);
    drive(4'bxxxx, 8'h00, 8'h00, 8'h40);
    check_ctrl("opx", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(4'hC, 8'h00, 8'h00, 8'h40);
    check("ld40_after_x", mem_rdata, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
